l1_port_arbiter: RTL and testbench

L1_PORT_ARBITER -- requirements
Module: l1_port_arbiter

---
 rtl/l1_port_arbiter_pkg.sv | 5 +
 rtl/l1_resp_demux.sv | 49 ++++
 rtl/l1_port_arbiter.sv | 75 +++++++
 tb/tb_l1_port_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/l1_port_arbiter_pkg.sv
// l1_port_arbiter_pkg: shared owner-tag and arbiter-state encodings
package l1_port_arbiter_pkg;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_IF = 2'd1, OWN_LS = 2'd2} owner_e;
  typedef enum logic {NORMAL = 1'b0, FETCH_PRIO = 1'b1} arb_state_e;
endpackage

// File: rtl/l1_resp_demux.sv
// l1_resp_demux: tags each read grant and steers the returning doubleword
module l1_resp_demux
  import l1_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              if_gnt_i,
  input  logic              ls_rd_gnt_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              ls_sel_i,
  input  logic [63:0]       mem_rdata_i,
  output logic              if_rvalid_o,
  output logic [63:0]       if_rdata_o,
  output logic [ADDR_W-1:0] if_raddr_o,
  output logic              ls_rvalid_o,
  output logic [31:0]       ls_rdata_o
);
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              sel_q, sel_d, if_v, ls_v;
  // next tag from this cycle's read grant; steer the doubleword returned for last cycle's grant
  always_comb begin
    owner_d     = if_gnt_i ? OWN_IF : ls_rd_gnt_i ? OWN_LS : OWN_NONE;
    addr_d      = if_gnt_i ? if_addr_i : addr_q;
    sel_d       = ls_rd_gnt_i ? ls_sel_i : sel_q;
    if_v        = (owner_q == OWN_IF) && !flush_i;
    ls_v        = owner_q == OWN_LS;
    if_rvalid_o = if_v;
    if_rdata_o  = if_v ? mem_rdata_i : '0;
    if_raddr_o  = if_v ? addr_q : '0;
    ls_rvalid_o = ls_v;
    ls_rdata_o  = ls_v ? (sel_q ? mem_rdata_i[63:32] : mem_rdata_i[31:0]) : '0;
  end
  // tag register; reset drops any read still in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_NONE;
      addr_q  <= '0;
      sel_q   <= 1'b0;
    end else begin
      owner_q <= owner_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
    end
  end
endmodule

// File: rtl/l1_port_arbiter.sv
// l1_port_arbiter: shares one memory port between fetch and load/store with starvation relief
module l1_port_arbiter
  import l1_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              hold_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [63:0]       if_rdata_o,
  output logic [ADDR_W-1:0] if_raddr_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [31:0]       ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [31:0]       ls_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [63:0]       mem_rdata_i
);
  localparam logic [2:0] SMAX = 3'(STARVE_MAX);
  arb_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       if_elig, if_win, ls_win;
  // pick the winner, drive the memory port, and advance starvation count and priority state
  always_comb begin
    if_elig     = if_req_i && !hold_i && !flush_i;
    if_win      = rst && if_elig && (state_q == FETCH_PRIO || !ls_req_i);
    ls_win      = rst && ls_req_i && !if_win;
    if_gnt_o    = if_win;
    ls_gnt_o    = ls_win;
    mem_en_o    = if_win || ls_win;
    mem_we_o    = ls_win && ls_we_i;
    mem_addr_o  = if_win ? {if_addr_i[ADDR_W-1:3], 3'b000} : ls_win ? ls_addr_i : '0;
    mem_wdata_o = ls_win ? ls_wdata_i : '0;
    cnt_d       = (!if_req_i || if_win) ? 3'd0 : (if_elig && cnt_q != SMAX) ? cnt_q + 3'd1 : cnt_q;
    state_d     = state_q == NORMAL ? (cnt_d == SMAX ? FETCH_PRIO : NORMAL)
                                    : ((if_win || !if_req_i) ? NORMAL : FETCH_PRIO);
  end
  // arbiter state and starvation counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= NORMAL;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  l1_resp_demux #(.ADDR_W(ADDR_W)) u_resp (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .if_gnt_i   (if_win),
    .ls_rd_gnt_i(ls_win && !ls_we_i),
    .if_addr_i  (if_addr_i),
    .ls_sel_i   (ls_addr_i[2]),
    .mem_rdata_i(mem_rdata_i),
    .if_rvalid_o(if_rvalid_o),
    .if_rdata_o (if_rdata_o),
    .if_raddr_o (if_raddr_o),
    .ls_rvalid_o(ls_rvalid_o),
    .ls_rdata_o (ls_rdata_o)
  );
endmodule

// File: tb/tb_l1_port_arbiter.sv
// tb_l1_port_arbiter: scoreboard bench with a behavioural arbitration model
module tb_l1_port_arbiter;
  localparam int SMAX = 4;
  logic        clk, rst, flush_i, hold_i, if_req_i, ls_req_i, ls_we_i;
  logic [31:0] if_addr_i, ls_addr_i, ls_wdata_i;
  logic [63:0] mem_rdata_i;
  logic        if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o, mem_en_o, mem_we_o;
  logic [63:0] if_rdata_o;
  logic [31:0] if_raddr_o, ls_rdata_o, mem_addr_o, mem_wdata_o;

  l1_port_arbiter dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .hold_i(hold_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o), .if_raddr_o(if_raddr_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  typedef struct {bit rs; bit ig; bit lg; bit en; bit we; logic [31:0] addr; logic [31:0] wd;} g_t;
  typedef struct {logic [63:0] data; logic [31:0] addr;} r_t;
  g_t          gq[$];
  r_t          ifq[$];
  logic [31:0] lsq[$];
  int          errors = 0, checks = 0;
  int          den = 0, pend = 0;
  logic [31:0] paddr = 0;
  bit          psel = 0;
  g_t          ge;
  r_t          re;
  logic [31:0] le;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic void chk(string n, logic [127:0] a, logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endfunction

  task automatic cyc(input bit r, input bit fl, input bit ho, input bit ir, input logic [31:0] ia,
                     input bit lr, input bit we, input logic [31:0] la, input logic [31:0] wd,
                     input logic [63:0] rd);
    bit elig, fw, lw;
    @(posedge clk);
    #1;
    rst = r; flush_i = fl; hold_i = ho; if_req_i = ir; if_addr_i = ia;
    ls_req_i = lr; ls_we_i = we; ls_addr_i = la; ls_wdata_i = wd; mem_rdata_i = rd;
    if (!r) begin
      den = 0;
      pend = 0;
      gq.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    end else begin
      if (pend == 1 && !fl) ifq.push_back('{rd, paddr});
      if (pend == 2) lsq.push_back(psel ? rd[63:32] : rd[31:0]);
      elig = ir && !ho && !fl;
      fw = elig && (den >= SMAX || !lr);
      lw = lr && !fw;
      gq.push_back('{1'b0, fw, lw, fw || lw, lw && we,
                     fw ? {ia[31:3], 3'b000} : la, wd});
      pend = fw ? 1 : (lw && !we) ? 2 : 0;
      if (fw) paddr = ia;
      if (lw && !we) psel = la[2];
      den = (!ir || fw) ? 0 : elig ? den + 1 : den;
    end
  endtask

  // monitor: compare port outputs and any presented response against the scoreboard
  always @(negedge clk) begin
    if (gq.size() > 0) begin
      ge = gq.pop_front();
      chk("if_gnt", if_gnt_o, ge.ig);
      chk("ls_gnt", ls_gnt_o, ge.lg);
      chk("mem_en", mem_en_o, ge.en);
      chk("mem_we", mem_we_o, ge.we);
      if (ge.en || ge.rs) chk("mem_addr", mem_addr_o, ge.rs ? 32'h0 : ge.addr);
      if (ge.lg || ge.rs) chk("mem_wdata", mem_wdata_o, ge.rs ? 32'h0 : ge.wd);
    end
    if (if_rvalid_o || ifq.size() > 0) begin
      chk("if_rvalid", if_rvalid_o, ifq.size() > 0);
      if (ifq.size() > 0) begin
        re = ifq.pop_front();
        chk("if_rdata", if_rdata_o, re.data);
        chk("if_raddr", if_raddr_o, re.addr);
      end
    end else chk("if_idle_zero", {if_rdata_o, if_raddr_o}, 0);
    if (ls_rvalid_o || lsq.size() > 0) begin
      chk("ls_rvalid", ls_rvalid_o, lsq.size() > 0);
      if (lsq.size() > 0) begin
        le = lsq.pop_front();
        chk("ls_rdata", ls_rdata_o, le);
      end
    end else chk("ls_idle_zero", ls_rdata_o, 0);
  end

  initial begin
    rst = 0; flush_i = 0; hold_i = 0; if_req_i = 0; ls_req_i = 0; ls_we_i = 0;
    if_addr_i = 0; ls_addr_i = 0; ls_wdata_i = 0; mem_rdata_i = 0;
    cyc(0, 0, 0, 1, 32'h100, 1, 1, 32'h10, 32'h55, 64'h1);
    @(negedge clk);
    chk("reset_outputs", {if_gnt_o, ls_gnt_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o}, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 32'h104, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD);
    @(negedge clk);
    chk("load_hi_word", {ls_rvalid_o, ls_rdata_o}, {1'b1, 32'hAAAA_BBBB});
    for (int i = 1; i <= 7; i++) begin
      cyc(1, 0, 0, 1, 32'h300 + 32'(i * 4), 1, 0, 32'h40, 0, {$urandom, $urandom});
      @(negedge clk);
      chk("starve_fetch_gnt", {if_gnt_o, ls_gnt_o}, (i == 5) ? 2'b10 : 2'b01);
    end
    cyc(1, 0, 0, 1, 32'h204, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 64'h1234_5678_9ABC_DEF0);
    @(negedge clk);
    chk("flush_kills_rvalid", if_rvalid_o, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 1, 32'h40, 1, 1, 32'h8, 32'hDEAD_BEEF, 0);
      @(negedge clk);
      chk("hold_store", {mem_we_o, if_gnt_o, ls_gnt_o, mem_addr_o}, {3'b101, 32'h8});
    end
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 1, 32'h48, 1, 1, 32'h8, 32'h1, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 32'h100, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    chk("rst_mid_read", {ls_rvalid_o, ls_rdata_o, if_rvalid_o, mem_en_o}, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    chk("no_rvalid_after_rst", ls_rvalid_o, 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 199) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0,
          $urandom_range(0, 9) < 8, $urandom, $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0,
          $urandom, $urandom, {$urandom, $urandom});
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 64'h0);
    @(negedge clk);
    #1;
    chk("queues_drained", gq.size() + ifq.size() + lsq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
